bsg_cover_sample_buffer: RTL

- Per-covergroup ping-pong sample buffer that sits directly upstream of the coverage AXI-stream packer; one instance per covergroup, all in the DUT (ds) clock domain.
- Captures coverage samples into one bank while the other bank drains to the packer as one burst.
- Burst framing: the packer emits the header; this block supplies the header fields (els/len), then N sample beats, then one trailer beat carrying the dropped-sample count, with last on the trailer only.

---
 rtl/bsg_cover_sample_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bsg_cover_sample_buffer.sv
// rtl/bsg_cover_sample_buffer.sv - ping-pong coverage sample buffer feeding the AXI-stream packer
// One bank captures samples while the other drains as a burst of data beats plus a drop-count trailer.
module bsg_cover_sample_buffer #(
  parameter int els_p        = 16,
  parameter int data_width_p = 64
) (
  input  logic                    ds_clk_i,
  input  logic                    ds_reset_n_i,
  input  logic                    v_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic                    flush_i,
  output logic                    gate_o,
  output logic [7:0]              els_o,
  output logic [7:0]              len_o,
  output logic                    v_o,
  output logic                    last_o,
  output logic [data_width_p-1:0] data_o,
  input  logic                    ready_i
);

  localparam int         idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [7:0] els_lp   = 8'(els_p);
  localparam logic [7:0] len_lp   = 8'(data_width_p / 8);

  typedef enum logic [1:0] {IDLE, DATA, TRAIL} state_e;

  state_e                  state_r;
  logic                    fsel_r;
  logic                    dsel_r;
  logic [7:0]              fcnt_r;
  logic [7:0]              ptr_r;
  logic [7:0]              dlen_r;
  logic [31:0]             drop_r;
  logic [31:0]             drop_snap_r;
  logic [data_width_p-1:0] bank_r [2][els_p];

  logic        accept;
  logic        drop;
  logic        swap;
  logic [31:0] drop_next;

  assign accept    = v_i & (fcnt_r < els_lp);
  assign drop      = v_i & (fcnt_r == els_lp);
  assign drop_next = (drop && (drop_r != 32'hFFFF_FFFF)) ? drop_r + 32'd1 : drop_r;
  // A sample accepted on the flush cycle still counts, so flush with one incoming sample is not "empty".
  assign swap      = (state_r == IDLE) &
                     ((fcnt_r == els_lp) | (flush_i & ((fcnt_r != 8'd0) | accept)));

  always_ff @(posedge ds_clk_i) begin
    if (accept) begin
      bank_r[fsel_r][fcnt_r[idx_w_lp-1:0]] <= data_i;
    end
  end

  always_ff @(posedge ds_clk_i) begin
    if (!ds_reset_n_i) begin
      state_r     <= IDLE;
      fsel_r      <= 1'b0;
      dsel_r      <= 1'b0;
      fcnt_r      <= 8'd0;
      ptr_r       <= 8'd0;
      dlen_r      <= 8'd0;
      drop_r      <= 32'd0;
      drop_snap_r <= 32'd0;
    end else if (swap) begin
      state_r     <= DATA;
      dsel_r      <= fsel_r;
      fsel_r      <= ~fsel_r;
      dlen_r      <= fcnt_r + {7'd0, accept};
      fcnt_r      <= 8'd0;
      ptr_r       <= 8'd0;
      drop_snap_r <= drop_next;
      drop_r      <= 32'd0;
    end else begin
      if (accept) begin
        fcnt_r <= fcnt_r + 8'd1;
      end
      drop_r <= drop_next;
      case (state_r)
        DATA: begin
          if (ready_i) begin
            ptr_r <= ptr_r + 8'd1;
            if (ptr_r == dlen_r - 8'd1) begin
              state_r <= TRAIL;
            end
          end
        end
        TRAIL: begin
          if (ready_i) begin
            state_r <= IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode straight from registered state, so they hold steady while ready_i is low.
  always_comb begin
    gate_o = 1'b0;
    v_o    = 1'b0;
    last_o = 1'b0;
    els_o  = 8'd0;
    len_o  = 8'd0;
    data_o = '0;
    case (state_r)
      DATA: begin
        gate_o = 1'b1;
        v_o    = 1'b1;
        els_o  = dlen_r;
        len_o  = len_lp;
        data_o = bank_r[dsel_r][ptr_r[idx_w_lp-1:0]];
      end
      TRAIL: begin
        gate_o = 1'b1;
        v_o    = 1'b1;
        last_o = 1'b1;
        els_o  = dlen_r;
        len_o  = len_lp;
        data_o = data_width_p'(drop_snap_r);
      end
      default: begin
      end
    endcase
  end

endmodule
